add_arbiter: RTL
================

Name: add_arbiter

Overview:
- Shares one 64-bit adder datapath among NREQ requesters in the SEQ core, e.g. the execute-stage ALU, valP/PC increment and rsp update.
- Grants one request per cycle using round-robin and computes sum and signed overflow through the shared adder.
- Returns the result in an output register with a valid/ready response channel tagged by requester ID.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- W, 64, operand and sum width.
- IDW, $clog2(NREQ) as a localparam, width of the requester ID.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*W  flattened operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  flattened operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit set.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_sum  out  W  a + b modulo 2^W.
- rsp_ovf  out  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is synchronous and active-high. When rst=1 at a clock edge:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf=0.
  - Round-robin pointer ptr=0; state=EMPTY.
  - Any in-flight result is discarded.
- req_ready is 0 throughout every cycle in which rst=1.
- Two-state FSM:
  - EMPTY: output register invalid.
  - FULL: rsp_valid=1.
- Slot availability: slot_free = (state==EMPTY) || rsp_ready.
- Arbitration (combinational):
  - Active only when slot_free=1.
  - Search requesters ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ). The first with req_valid=1 gets its req_ready bit set.
  - When slot_free=0, req_ready is all zeros.
- Transfer occurs when req_valid[g] and req_ready[g] are both high. At that clock edge:
  - The output register loads sum/ovf from the adder applied to requester g's operands.
  - rsp_id=g; state goes to FULL.
  - ptr=(g+1) mod NREQ.
- Latency is exactly 1 cycle from transfer to rsp_valid=1. Sustained throughput is 1 result per cycle while rsp_ready=1.
- Response handshake:
  - In FULL with rsp_ready=1 and no new transfer, go to EMPTY.
  - In FULL with rsp_ready=1 and a new transfer on the same edge, stay FULL with the new contents (back-to-back, no bubble).
  - In FULL with rsp_ready=0, hold rsp_* stable and grant nothing.
- ptr is unchanged on any cycle without a transfer.
- A requester holds req_valid, req_a and req_b stable until its transfer. req_valid dropping before grant is legal and simply withdraws the request.
- Arithmetic: no carry-in and no carry-out port. Subtraction is the requester's responsibility: it presents the two's complement of B.
  - Wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 gives sum=0, ovf=0.
- Datapath: a single adder instance, fed by a NREQ:1 operand mux driven by the one-hot grant.
- Simultaneous requests from every requester are granted strictly in rotation; no requester waits more than NREQ-1 grants.

Optional Feature:
- Macro: ADD_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants (NREQ*16): per-requester 16-bit grant counters that saturate at 0xFFFF.
  - Adds output stat_ovf (16): saturating count of transfers whose result has ovf=1, counted at load time.
  - All counters clear on rst.
- When undefined: these ports and counters do not exist. Arbitration and timing are identical in both builds.

Decomposition:
- Shared package (add_arb_pkg):
  - Constants W_DEFAULT=64, CNT_W=16.
  - State typedef for the enum {EMPTY, FULL}.
- One sub-module, rr_pick:
  - Inputs: NREQ-bit request vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- add_arbiter instantiates rr_pick, the existing 64-bit adder, the operand mux and the output register/FSM.

Test Plan:
- Reset: rst high 2 cycles with all req_valid=1.
  - Expect req_ready=0, rsp_valid=0, rsp_sum=0.
  - After release, first grant goes to requester 0.
- Single request, NREQ=2:
  - req0 a=5, b=7, rsp_ready=1.
  - Expect rsp_valid=1 next cycle, rsp_sum=12, rsp_id=0, rsp_ovf=0.
- Overflow:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1 gives sum=0x8000_0000_0000_0000, ovf=1.
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1 gives sum=0, ovf=0.
- Fairness:
  - Both requesters valid continuously for 6 cycles, rsp_ready=1.
  - Expect rsp_id sequence 0,1,0,1,0,1 with no bubbles.
- Backpressure:
  - rsp_ready=0 for 3 cycles while FULL.
  - Expect rsp_* stable, req_ready=0.
  - Raise rsp_ready with req1 pending; expect same-edge reload and rsp_id=1 the next cycle.
- Reset mid-operation:
  - rst asserted while FULL and req0 pending.
  - Expect rsp_valid=0 and ptr=0 next cycle, and the pending result is dropped.
  - With ADD_ARB_STATS_EN defined, counters also read 0.

Source files
------------

// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared constants and state type for the add arbiter
package add_arb_pkg;

    localparam int W_DEFAULT = 64;
    localparam int CNT_W     = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/add_arbiter_adder.sv
// rtl/add_arbiter_adder.sv - W-bit adder with signed overflow (carry into MSB xor carry out)
module add_core #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] w_full;
    logic       w_carry_msb_in;

    assign w_full         = {1'b0, a} + {1'b0, b};
    assign sum            = w_full[W-1:0];
    // a^b^sum at the MSB recovers the carry that entered that bit
    assign w_carry_msb_in = a[W-1] ^ b[W-1] ^ w_full[W-1];
    assign ovf            = w_carry_msb_in ^ w_full[W];

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// rtl/add_arbiter_rr_pick.sv - combinational round-robin picker, first requester at or after ptr wins
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (en && !found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin shared adder with registered tagged response
// Optional grant/overflow statistics counters under ADD_ARB_STATS_EN.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int W    = W_DEFAULT,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_ovf
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] stat_grants,
    output logic [CNT_W-1:0]      stat_ovf
`endif
);

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_sum;
    logic           r_rsp_ovf;

    logic            w_slot_free;
    logic            w_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_xfer;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [W-1:0]    w_sum;
    logic            w_ovf;
    logic [IDW-1:0]  w_ptr_nxt;

    assign w_slot_free = (r_state == EMPTY) || rsp_ready;
    assign w_en        = w_slot_free && !rst;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (w_en),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |(req_valid & w_gnt);

    // One-hot AND-OR operand mux: a zero grant feeds zeros into the adder
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a = w_a | req_a[i*W +: W];
                w_b = w_b | req_b[i*W +: W];
            end
        end
    end

    add_core #(.W(W)) u_add (
        .a   (w_a),
        .b   (w_b),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_ptr     <= '0;
            r_rsp_id  <= '0;
            r_rsp_sum <= '0;
            r_rsp_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_state   <= FULL;
            r_ptr     <= w_ptr_nxt;
            r_rsp_id  <= w_idx;
            r_rsp_sum <= w_sum;
            r_rsp_ovf <= w_ovf;
        end else if (r_state == FULL && rsp_ready) begin
            r_state <= EMPTY;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_ovf   = r_rsp_ovf;

`ifdef ADD_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt [NREQ];
    logic [CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_ovf_cnt <= '0;
        end else if (w_xfer) begin
            if (r_grant_cnt[w_idx] != '1) begin
                r_grant_cnt[w_idx] <= r_grant_cnt[w_idx] + CNT_W'(1);
            end
            if (w_ovf && r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        assign stat_grants[gi*CNT_W +: CNT_W] = r_grant_cnt[gi];
    end
    assign stat_ovf = r_ovf_cnt;
`endif

endmodule
